// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   scan_state_t : scanner FSM states (SCAN, EVAL)
//   KEY_ROWS/KEY_COLS/KEY_CODE_W : matrix geometry and event code width
//   onehot16()   : true when exactly one of 16 bits is set
//   idx16()      : index of the highest set bit (used on one-hot inputs)
package keypad_pkg;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } scan_state_t;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 5;

  function automatic logic onehot16(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] idx16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/key_evt_reg.sv
// key_evt_reg: single-entry valid/ready event register with sticky overflow.
//   clk, rst      : clock, synchronous active-high reset
//   evt_valid     : one-cycle event strobe from the producer
//   evt_code      : event payload
//   key_ready     : consumer accepts when key_valid & key_ready
//   key_valid     : event held in the register
//   key_code      : held payload, stable while key_valid=1
//   overflow      : set when an event arrives and the register cannot take it
module key_evt_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         evt_valid,
  input  logic [W-1:0] evt_code,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [W-1:0] key_code,
  output logic         overflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else if (evt_valid) begin
      // A handshake in the same cycle frees the slot for the new event.
      if (!key_valid || key_ready) begin
        key_code  <= evt_code;
        key_valid <= 1'b1;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan44.sv
// keypad_scan44: 4x4 matrix keypad scanner with whole-snapshot debounce.
//   clk, rst  : clock, synchronous active-high reset
//   row_out   : active-low one-cold row drive (4'b1111 during EVAL)
//   col_in    : active-low column sense (pulled up on the board)
//   key_code  : {release, row*4+col}
//   key_valid / key_ready : event handshake
//   key_held  : accepted snapshot has at least one key down
//   overflow  : sticky, an event was dropped
// Build option: define KEYSCAN_RELEASE_EV_EN to emit release events
// (key_code[4]=1) when a single held key goes back to no keys.
module keypad_scan44
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int DEB_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [3:0]            row_out,
  input  logic [3:0]            col_in,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  key_held,
  output logic                  overflow
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int MATCH_W = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEB_SCANS);

  scan_state_t         state, state_nxt;
  logic [DIV_W-1:0]    div;
  logic [1:0]          row;
  logic [15:0]         frame, snapshot, stable;
  logic [MATCH_W-1:0]  match, match_inc, match_nxt;
  logic                slot_end, accept, press_ev;
  logic                evt_valid;
  logic [KEY_CODE_W-1:0] evt_code;

  assign slot_end = (state == ST_SCAN) && (div == DIV_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_SCAN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_out   = 4'b1111;
    case (state)
      ST_SCAN: begin
        row_out = ~(4'b0001 << row);
        if (slot_end && row == 2'd3) state_nxt = ST_EVAL;
      end
      ST_EVAL: state_nxt = ST_SCAN;
      default: state_nxt = ST_SCAN;
    endcase
  end

  // Debounce: match saturates at DEB_SCANS; a non-zero updated match implies
  // frame==snapshot, so frame is the snapshot being accepted.
  assign match_inc = (match == MATCH_MAX) ? match : match + 1'b1;
  assign match_nxt = (frame == snapshot) ? match_inc : '0;
  assign accept    = (state == ST_EVAL) && (match_nxt == MATCH_MAX) && (frame != stable);
  assign press_ev  = (stable == 16'd0) && onehot16(frame);

`ifdef KEYSCAN_RELEASE_EV_EN
  logic rel_ev;
  assign rel_ev    = onehot16(stable) && (frame == 16'd0);
  assign evt_valid = accept && (press_ev || rel_ev);
  assign evt_code  = rel_ev ? {1'b1, idx16(stable)} : {1'b0, idx16(frame)};
`else
  assign evt_valid = accept && press_ev;
  assign evt_code  = {1'b0, idx16(frame)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      row      <= 2'd0;
      frame    <= 16'd0;
      snapshot <= 16'd0;
      stable   <= 16'd0;
      match    <= '0;
      key_held <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (slot_end) begin
            div <= '0;
            frame[{row, 2'b00} +: 4] <= ~col_in;
            if (row != 2'd3) row <= row + 2'd1;
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_EVAL: begin
          row      <= 2'd0;
          div      <= '0;
          match    <= match_nxt;
          snapshot <= frame;
          if (accept) begin
            stable   <= frame;
            key_held <= (frame != 16'd0);
          end
        end
        default: ;
      endcase
    end
  end

  key_evt_reg #(.W(KEY_CODE_W)) u_evt (
    .clk       (clk),
    .rst       (rst),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_code  (key_code),
    .overflow  (overflow)
  );

endmodule
